// File: rtl/serial_compare_unit.sv
// Multi-cycle compare unit: forms a + ~b + 1 one CHUNK per clock (LSB first) and
// reports SLT/SLTU/SEQ/SNE together with carryout, overflow and zero flags.
module serial_compare_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_p0, nb_p0;
    logic [1:0]       mode_p0;
    logic             carry_p0, zacc_p0;
    logic [CNT_W-1:0] cnt_p0;

    logic [CHUNK-1:0] a_ch, nb_ch, sum_ch;
    logic             c_out, msb_cin, last, zero_fin, accept;

    function automatic logic cmp_outcome(input logic [1:0] m, input logic sign,
                                         input logic ovf, input logic co, input logic z);
        logic r;
        case (m)
            2'b00:   r = sign ^ ovf;
            2'b01:   r = ~co;
            2'b10:   r = z;
            default: r = ~z;
        endcase
        return r;
    endfunction

    always_comb begin
        a_ch  = a_p0[cnt_p0*CHUNK +: CHUNK];
        nb_ch = nb_p0[cnt_p0*CHUNK +: CHUNK];
        {c_out, sum_ch} = {1'b0, a_ch} + {1'b0, nb_ch} + {{CHUNK{1'b0}}, carry_p0};
        // Carry into the top bit is recovered from its sum and operand bits.
        msb_cin  = sum_ch[CHUNK-1] ^ a_ch[CHUNK-1] ^ nb_ch[CHUNK-1];
        last     = (cnt_p0 == CNT_W'(NCHUNK - 1));
        zero_fin = zacc_p0 & ~(|sum_ch);
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE) && !reset;
        out_valid = (state == DONE);
        accept    = in_valid && in_ready;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0    <= a;
            nb_p0   <= ~b;
            mode_p0 <= mode;
        end
    end

    // Serial add stage and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt_p0   <= '0;
            carry_p0 <= 1'b1;
            zacc_p0  <= 1'b1;
            result   <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept) begin
                carry_p0 <= 1'b1;
                zacc_p0  <= 1'b1;
                cnt_p0   <= '0;
            end else if (state == RUN) begin
                carry_p0 <= c_out;
                zacc_p0  <= zero_fin;
                if (last) begin
                    carryout <= c_out;
                    overflow <= msb_cin ^ c_out;
                    zero     <= zero_fin;
                    result   <= {{(WIDTH-1){1'b0}},
                                 cmp_outcome(mode_p0, sum_ch[CHUNK-1], msb_cin ^ c_out, c_out, zero_fin)};
                end else begin
                    cnt_p0 <= cnt_p0 + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_compare_unit.sv
// Bench for serial_compare_unit: three instances (32/8, 32/32, 8/1) checked against
// an arithmetic reference model with directed and random operations.
module tb_serial_compare_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a_in, b_in;
    logic [1:0]  mode_in;
    logic        out_ready;
    logic        iv  [3];
    logic        ir  [3];
    logic        ovl [3];
    logic [31:0] res [3];
    logic        co  [3];
    logic        of  [3];
    logic        zz  [3];
    logic [7:0]  res8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_compare_unit #(.WIDTH(32), .CHUNK(8)) u_d0 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_in), .b(b_in), .mode(mode_in), .out_valid(ovl[0]), .out_ready(out_ready),
        .result(res[0]), .carryout(co[0]), .overflow(of[0]), .zero(zz[0]));

    serial_compare_unit #(.WIDTH(32), .CHUNK(32)) u_d1 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_in), .b(b_in), .mode(mode_in), .out_valid(ovl[1]), .out_ready(out_ready),
        .result(res[1]), .carryout(co[1]), .overflow(of[1]), .zero(zz[1]));

    serial_compare_unit #(.WIDTH(8), .CHUNK(1)) u_d2 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_in[7:0]), .b(b_in[7:0]), .mode(mode_in), .out_valid(ovl[2]), .out_ready(out_ready),
        .result(res8), .carryout(co[2]), .overflow(of[2]), .zero(zz[2]));

    assign res[2] = {24'b0, res8};

    function automatic int width_of(input int k);
        return (k == 2) ? 8 : 32;
    endfunction

    function automatic int nchunk_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 1 : 8;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                  input logic [1:0] m, output logic r, output logic c,
                                  output logic v, output logic z);
        longint mask, au, bu, sa, sb, d, smax;
        mask = (longint'(1) << w) - 1;
        smax = mask >> 1;
        au = longint'(av) & mask;
        bu = longint'(bv) & mask;
        sa = (au > smax) ? au - (mask + 1) : au;
        sb = (bu > smax) ? bu - (mask + 1) : bu;
        d  = sa - sb;
        c  = (au >= bu);
        z  = (au == bu);
        v  = (d > smax) || (d < -(smax + 1));
        case (m)
            2'b00:   r = (sa < sb);
            2'b01:   r = (au < bu);
            2'b10:   r = z;
            default: r = !z;
        endcase
    endfunction

    task automatic start_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                            input logic [1:0] m);
        int n = 0;
        while (!ir[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", 32'(ir[k]), 32'd1);
        a_in = av; b_in = bv; mode_in = m; iv[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[k] = 1'b0;
        a_in = $urandom; b_in = $urandom; mode_in = 2'($urandom_range(3, 0));
    endtask

    task automatic wait_done(input int k, output int lat);
        lat = 0;
        while (!ovl[k] && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", 32'(lat), 32'(nchunk_of(k)));
    endtask

    task automatic check_out(input int k, input logic [31:0] av, input logic [31:0] bv,
                             input logic [1:0] m);
        logic r, c, v, z;
        model(width_of(k), av, bv, m, r, c, v, z);
        check("result", res[k], {31'b0, r});
        check("carryout", 32'(co[k]), 32'(c));
        check("overflow", 32'(of[k]), 32'(v));
        check("zero", 32'(zz[k]), 32'(z));
    endtask

    task automatic release_out(input int k);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_release", 32'(ovl[k]), 32'd0);
        check("in_ready_after_release", 32'(ir[k]), 32'd1);
    endtask

    task automatic run_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                          input logic [1:0] m);
        int lat;
        start_op(k, av, bv, m);
        wait_done(k, lat);
        check_out(k, av, bv, m);
        release_out(k);
    endtask

    task automatic directed(input int k);
        run_op(k, 32'hFFFF_FFFF, 32'h0000_0001, 2'b00);
        run_op(k, 32'hFFFF_FFFF, 32'h0000_0001, 2'b01);
        if (k == 2) begin
            run_op(k, 32'h80, 32'h01, 2'b00);
            run_op(k, 32'h80, 32'h01, 2'b01);
            run_op(k, 32'h78, 32'h78, 2'b10);
            run_op(k, 32'h78, 32'h78, 2'b11);
        end else begin
            run_op(k, 32'h8000_0000, 32'h1, 2'b00);
            run_op(k, 32'h8000_0000, 32'h1, 2'b01);
            run_op(k, 32'h1234_5678, 32'h1234_5678, 2'b10);
            run_op(k, 32'h1234_5678, 32'h1234_5678, 2'b11);
        end
        run_op(k, 32'h0, 32'h1, 2'b11);
    endtask

    initial begin
        logic [31:0] snap_r;
        logic        snap_c, snap_v, snap_z;
        int          lat;
        logic [31:0] ra, rb;

        for (int i = 0; i < 3; i++) iv[i] = 1'b0;
        out_ready = 1'b0;
        a_in = '0; b_in = '0; mode_in = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset_out_valid", 32'(ovl[k]), 32'd0);
            check("reset_in_ready", 32'(ir[k]), 32'd0);
            check("reset_result", res[k], 32'd0);
            check("reset_flags", {29'b0, co[k], of[k], zz[k]}, 32'd0);
        end
        reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) check("in_ready_after_reset", 32'(ir[k]), 32'd1);

        for (int k = 0; k < 3; k++) directed(k);

        // Backpressure: hold DONE, pulse new operands, expect nothing to move.
        start_op(0, 32'hFFFF_FFFF, 32'h1, 2'b00);
        wait_done(0, lat);
        snap_r = res[0]; snap_c = co[0]; snap_v = of[0]; snap_z = zz[0];
        check("bp_result", snap_r, 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                a_in = 32'h0; b_in = 32'h0; mode_in = 2'b10; iv[0] = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            iv[0] = 1'b0;
            check("bp_out_valid", 32'(ovl[0]), 32'd1);
            check("bp_in_ready", 32'(ir[0]), 32'd0);
            check("bp_result_hold", res[0], snap_r);
            check("bp_flags_hold", {29'b0, co[0], of[0], zz[0]}, {29'b0, snap_c, snap_v, snap_z});
        end
        release_out(0);
        check("bp_result_after_idle", res[0], snap_r);

        // Reset during the second RUN cycle discards the operation.
        start_op(0, 32'h5, 32'h3, 2'b00);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_run_out_valid", 32'(ovl[0]), 32'd0);
        check("rst_run_result", res[0], 32'd0);
        check("rst_run_flags", {29'b0, co[0], of[0], zz[0]}, 32'd0);
        check("rst_run_in_ready_low", 32'(ir[0]), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_run_in_ready", 32'(ir[0]), 32'd1);
        @(negedge clk);
        check("rst_run_no_result", 32'(ovl[0]), 32'd0);
        run_op(0, 32'd3, 32'd5, 2'b01);
        check("sltu_3_5", res[0], 32'd1);

        // Random operations; equal operands forced now and then.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < ((k == 0) ? 300 : 1000); i++) begin
                ra = $urandom;
                rb = ($urandom_range(7, 0) == 0) ? ra : $urandom;
                if ($urandom_range(3, 0) == 0) rb = {ra[31], rb[30:0]};
                run_op(k, ra, rb, 2'($urandom_range(3, 0)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
